pc_fetch: RTL and testbench
===========================

Name: pc_fetch

Overview:
- Program-counter and next-address stage of the single-cycle MIPS.
- Holds the PC register and drives the instruction memory address, which the memory reads combinationally on a word basis.
- Computes the next PC for sequential flow, branch, j/jal and jr. Tracks run/halt/error state and counts executed instructions.

Parameters:
- RESET_PC, 32'h0000_0000, byte address loaded into PC on reset
- MEM_WORDS, 256, number of instruction words; word index of any PC must be < MEM_WORDS
- HALT_WORD, 32'h0000_000C (syscall), instruction encoding that stops fetch

Ports:
- clock  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- en  in  1  advance enable; 0 = stall (PC and counter hold)
- instr  in  32  current instruction from instruction memory (for jump field and halt detect)
- branch_taken  in  1  from control/ALU: conditional branch taken this cycle
- imm_ext  in  32  sign-extended 16-bit immediate
- jump  in  1  j/jal this cycle
- jr  in  1  jr this cycle
- rs_data  in  32  register rs value (jr target)
- pc  out  32  current PC (byte address)
- pc_plus4  out  32  pc + 4, combinational (jal link value)
- halted  out  1  1 while in HALT
- error  out  1  1 while in ERROR
- instr_count  out  32  executed-instruction counter

Behaviour:
- Reset (reset_n=0, async):
  - pc=RESET_PC, state=RUN, instr_count=0, halted=0, error=0.
  - Deassertion takes effect on the next rising edge.
- pc_plus4 = pc + 4, modulo 2^32.
- Next-PC candidates, with priority jr > jump > branch_taken > sequential:
  - jr: next = rs_data.
  - jump: next = {pc_plus4[31:28], instr[25:0], 2'b00}.
  - branch: next = pc_plus4 + (imm_ext << 2), modulo 2^32.
  - sequential: next = pc_plus4.
- States RUN, HALT, ERROR. All updates occur on the rising edge.
- RUN with en=0: no change at all (stall).
- RUN with en=1, evaluated in this order:
  1. instr == HALT_WORD: pc holds, instr_count += 1, go to HALT. Control inputs are ignored that cycle.
  2. Else if selected next has next[1:0] != 0 (misaligned, only reachable via jr), or next[31:2] >= MEM_WORDS: pc holds, instr_count += 1, go to ERROR.
  3. Else pc <= next, instr_count += 1, stay in RUN.
- HALT: absorbing; pc, instr_count hold; halted=1. Only reset exits.
- ERROR: absorbing; pc, instr_count hold; error=1. Only reset exits. pc keeps the address of the faulting instruction.
- halted and error are registered state decodes, never both 1.
- instr_count saturates at 32'hFFFF_FFFF; no wrap.
- Reset asserted mid-cycle or mid-stall overrides everything immediately.
- Latency:
  - pc changes one clock edge after the control inputs are sampled.
  - pc_plus4 follows pc combinationally in the same cycle.
- Self-loop (branch to self, imm_ext = -1) is legal: pc stays constant, counter keeps incrementing.

Test Plan:
- Reset then 4 edges, en=1, no control, instr=NOP → pc = 0x0, 0x4, 0x8, 0xC, 0x10; instr_count = 4.
- At pc=0x10, branch_taken=1, imm_ext=32'hFFFF_FFFE → pc = 0x0C; branch with imm_ext=3 from 0x0C → 0x1C.
- jump=1, instr=32'h0800_0010 at pc=0x20 → pc = 0x40. Same edge with jr=1, rs_data=0x8 → pc = 0x8 (jr wins).
- jr with rs_data=0x6 → error=1, pc holds. Separately, jr with rs_data=0x400 (index 256, MEM_WORDS=256) → error=1. Neither case recovers until reset.
- instr=HALT_WORD with en=1 → halted=1 next edge, pc frozen, counter +1 then frozen. With en=0 and instr=HALT_WORD → still RUN.
- Stall en=0 for 3 cycles mid-run → pc and instr_count unchanged. Pulse reset_n low between edges → pc=0, instr_count=0 asynchronously.

Source files
------------

// File: rtl/pc_fetch.sv
// Program counter and next-address stage of the single-cycle MIPS core.
// Selects the next PC (jr > jump > branch > sequential), tracks run/halt/error, counts retired instructions.
module pc_fetch #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned MEM_WORDS = 256,
  parameter logic [31:0] HALT_WORD = 32'h0000_000C
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        en,
  input  logic [31:0] instr,
  input  logic        branch_taken,
  input  logic [31:0] imm_ext,
  input  logic        jump,
  input  logic        jr,
  input  logic [31:0] rs_data,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        halted,
  output logic        error,
  output logic [31:0] instr_count
);

  localparam int unsigned ADDR_W = 32;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_HALT  = 2'd1,
    ST_ERROR = 2'd2
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] branch_target;
  logic [ADDR_W-1:0] jump_target;
  logic [ADDR_W-1:0] next_pc;
  logic              next_bad;
  logic              is_halt;
  logic [31:0]       count_inc;

  // Next-address candidates and priority select
  always_comb begin
    pc_plus4      = pc + ADDR_W'(4);
    branch_target = pc_plus4 + (imm_ext << 2);
    jump_target   = {pc_plus4[31:28], instr[25:0], 2'b00};
    next_pc       = pc_plus4;
    if (jr) begin
      next_pc = rs_data;
    end else if (jump) begin
      next_pc = jump_target;
    end else if (branch_taken) begin
      next_pc = branch_target;
    end
  end

  // Fault / halt detection and saturating counter increment
  always_comb begin
    is_halt   = (instr == HALT_WORD);
    next_bad  = (next_pc[1:0] != 2'b00) ||
                (32'(next_pc[31:2]) >= 32'(MEM_WORDS));
    count_inc = (instr_count == 32'hFFFF_FFFF) ? instr_count
                                               : instr_count + 32'd1;
  end

  // State, PC and counter; halted/error are registered decodes of the next state
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_RUN;
      pc          <= RESET_PC;
      instr_count <= 32'd0;
      halted      <= 1'b0;
      error       <= 1'b0;
    end else begin
      case (state)
        ST_RUN: begin
          if (en) begin
            instr_count <= count_inc;
            if (is_halt) begin
              state  <= ST_HALT;
              halted <= 1'b1;
            end else if (next_bad) begin
              state <= ST_ERROR;
              error <= 1'b1;
            end else begin
              pc <= next_pc;
            end
          end
        end
        ST_HALT: begin
          halted <= 1'b1;
          error  <= 1'b0;
        end
        ST_ERROR: begin
          halted <= 1'b0;
          error  <= 1'b1;
        end
        default: begin
          state  <= ST_ERROR;
          halted <= 1'b0;
          error  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_fetch.sv
// Directed, table-driven bench for pc_fetch with hand-computed expectations
// plus short sequences for async reset and the error corner cases.
module tb_pc_fetch;

  localparam logic [31:0] NOP  = 32'h0000_0000;
  localparam logic [31:0] HALT = 32'h0000_000C;

  logic        clock;
  logic        reset_n;
  logic        en;
  logic [31:0] instr;
  logic        branch_taken;
  logic [31:0] imm_ext;
  logic        jump;
  logic        jr;
  logic [31:0] rs_data;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        halted;
  logic        error;
  logic [31:0] instr_count;

  int checks = 0;
  int errors = 0;

  pc_fetch #(
    .RESET_PC (32'h0000_0000),
    .MEM_WORDS(256),
    .HALT_WORD(32'h0000_000C)
  ) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .en          (en),
    .instr       (instr),
    .branch_taken(branch_taken),
    .imm_ext     (imm_ext),
    .jump        (jump),
    .jr          (jr),
    .rs_data     (rs_data),
    .pc          (pc),
    .pc_plus4    (pc_plus4),
    .halted      (halted),
    .error       (error),
    .instr_count (instr_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic        en;
    logic [31:0] instr;
    logic        br;
    logic [31:0] imm;
    logic        jmp;
    logic        jr;
    logic [31:0] rs;
    logic [31:0] e_pc;
    logic [31:0] e_cnt;
    logic        e_halt;
    logic        e_err;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic e, logic [31:0] ins, logic b, logic [31:0] im,
                              logic j, logic r, logic [31:0] rs,
                              logic [31:0] epc, logic [31:0] ecnt, logic eh, logic ee);
    vec_t v;
    v.en = e; v.instr = ins; v.br = b; v.imm = im; v.jmp = j; v.jr = r; v.rs = rs;
    v.e_pc = epc; v.e_cnt = ecnt; v.e_halt = eh; v.e_err = ee;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [31:0] epc, input logic [31:0] ecnt,
                           input logic eh, input logic ee);
    chk({tag, " pc"}, pc, epc);
    chk({tag, " pc_plus4"}, pc_plus4, epc + 32'd4);
    chk({tag, " instr_count"}, instr_count, ecnt);
    chk({tag, " halted"}, 32'(halted), 32'(eh));
    chk({tag, " error"}, 32'(error), 32'(ee));
  endtask

  // Drive on the falling edge, sample 1 time unit after the rising edge
  task automatic step(input vec_t v);
    @(negedge clock);
    en = v.en; instr = v.instr; branch_taken = v.br; imm_ext = v.imm;
    jump = v.jmp; jr = v.jr; rs_data = v.rs;
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset_n = 1'b0;
    en = 1'b0; instr = NOP; branch_taken = 1'b0; imm_ext = 32'd0;
    jump = 1'b0; jr = 1'b0; rs_data = 32'd0;
    #2;
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n = 1'b0;
    en = 1'b0; instr = NOP; branch_taken = 1'b0; imm_ext = 32'd0;
    jump = 1'b0; jr = 1'b0; rs_data = 32'd0;
    #12;
    check_all("reset", 32'h0, 32'd0, 1'b0, 1'b0);
    reset_n = 1'b1;

    //               en instr           br imm            j  jr rs            pc            cnt  h  e
    vecs.push_back(mk(1, NOP,           0, 32'd0,         0, 0, 32'd0,        32'h04,       1,   0, 0));
    vecs.push_back(mk(1, NOP,           0, 32'd0,         0, 0, 32'd0,        32'h08,       2,   0, 0));
    vecs.push_back(mk(1, NOP,           0, 32'd0,         0, 0, 32'd0,        32'h0C,       3,   0, 0));
    vecs.push_back(mk(1, NOP,           0, 32'd0,         0, 0, 32'd0,        32'h10,       4,   0, 0));
    vecs.push_back(mk(1, NOP,           1, 32'hFFFF_FFFE, 0, 0, 32'd0,        32'h0C,       5,   0, 0));
    vecs.push_back(mk(1, NOP,           1, 32'd3,         0, 0, 32'd0,        32'h1C,       6,   0, 0));
    vecs.push_back(mk(1, NOP,           0, 32'd0,         0, 0, 32'd0,        32'h20,       7,   0, 0));
    vecs.push_back(mk(1, 32'h0800_0010, 0, 32'd0,         1, 0, 32'd0,        32'h40,       8,   0, 0));
    vecs.push_back(mk(0, NOP,           1, 32'd5,         0, 0, 32'd0,        32'h40,       8,   0, 0));
    vecs.push_back(mk(0, HALT,          0, 32'd0,         0, 0, 32'd0,        32'h40,       8,   0, 0));
    vecs.push_back(mk(0, 32'h0800_0010, 0, 32'd0,         1, 1, 32'h8,        32'h40,       8,   0, 0));
    vecs.push_back(mk(1, 32'h0800_0010, 1, 32'd7,         1, 1, 32'h8,        32'h08,       9,   0, 0));
    vecs.push_back(mk(1, NOP,           1, 32'hFFFF_FFFF, 0, 0, 32'd0,        32'h08,       10,  0, 0));
    vecs.push_back(mk(1, NOP,           1, 32'hFFFF_FFFF, 0, 0, 32'd0,        32'h08,       11,  0, 0));
    vecs.push_back(mk(1, HALT,          1, 32'd40,        0, 1, 32'h6,        32'h08,       12,  1, 0));
    vecs.push_back(mk(1, NOP,           0, 32'd0,         0, 0, 32'd0,        32'h08,       12,  1, 0));
    vecs.push_back(mk(1, NOP,           0, 32'd0,         1, 0, 32'd0,        32'h08,       12,  1, 0));

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i]);
      check_all($sformatf("vec%0d", i), vecs[i].e_pc, vecs[i].e_cnt, vecs[i].e_halt, vecs[i].e_err);
    end

    // Async reset mid-stall, between edges, from a running state
    do_reset();
    step(mk(1, NOP, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    step(mk(1, NOP, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    check_all("pre_async", 32'h08, 32'd2, 1'b0, 1'b0);
    @(negedge clock);
    en = 1'b0;
    #1;
    reset_n = 1'b0;
    #1;
    check_all("async_reset", 32'h0, 32'd0, 1'b0, 1'b0);
    reset_n = 1'b1;

    // Misaligned jr target: error, pc holds, never recovers
    step(mk(1, NOP, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    check_all("mis_pre", 32'h04, 32'd1, 1'b0, 1'b0);
    step(mk(1, NOP, 0, 0, 0, 1, 32'h6, 0, 0, 0, 0));
    check_all("mis_err", 32'h04, 32'd2, 1'b0, 1'b1);
    step(mk(1, NOP, 0, 0, 0, 1, 32'h8, 0, 0, 0, 0));
    check_all("mis_stuck", 32'h04, 32'd2, 1'b0, 1'b1);
    step(mk(1, HALT, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    check_all("mis_stuck2", 32'h04, 32'd2, 1'b0, 1'b1);

    // Range boundary: last word is legal, one past it faults
    do_reset();
    step(mk(1, NOP, 0, 0, 0, 1, 32'h3FC, 0, 0, 0, 0));
    check_all("last_word", 32'h3FC, 32'd1, 1'b0, 1'b0);
    step(mk(1, NOP, 0, 0, 0, 1, 32'h400, 0, 0, 0, 0));
    check_all("oor_err", 32'h3FC, 32'd2, 1'b0, 1'b1);
    step(mk(1, NOP, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    check_all("oor_stuck", 32'h3FC, 32'd2, 1'b0, 1'b1);

    // Sequential fall-off past the last word also faults
    do_reset();
    step(mk(1, NOP, 0, 0, 0, 1, 32'h3FC, 0, 0, 0, 0));
    step(mk(1, NOP, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    check_all("seq_oor", 32'h3FC, 32'd2, 1'b0, 1'b1);

    // Reset from ERROR returns to RUN
    do_reset();
    #1;
    check_all("err_reset", 32'h0, 32'd0, 1'b0, 1'b0);
    step(mk(1, NOP, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    check_all("after_reset", 32'h04, 32'd1, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
